// File: rtl/dropout_mask_gen_if.sv
// Mask generator control/handshake bundle.
// master: mask producer; slave: controller and dropout stage.
interface dropout_mask_gen_if #(
    parameter int LANES = 8
);
    logic             enable;
    logic             seed_load;
    logic [15:0]      seed;
    logic [7:0]       threshold;
    logic             mask_valid;
    logic             mask_ready;
    logic [LANES-1:0] mask;
    logic [3:0]       drop_count;
    logic [15:0]      masks_issued;
    logic             busy;

    modport master (
        input  enable, seed_load, seed, threshold, mask_ready,
        output mask_valid, mask, drop_count, masks_issued, busy
    );

    modport slave (
        output enable, seed_load, seed, threshold, mask_ready,
        input  mask_valid, mask, drop_count, masks_issued, busy
    );
endinterface

// File: rtl/dropout_mask_gen.sv
// Per-lane LFSR dropout mask generator with valid/ready output.
// Ports: clk, reset_n (async low), bus (dropout_mask_gen_if.master).
module dropout_mask_gen #(
    parameter int          LANES         = 8,
    parameter logic [15:0] DEFAULT_SEED  = 16'hACE1,
    parameter int          WARMUP_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    dropout_mask_gen_if.master bus
);
    localparam int CW = $clog2(WARMUP_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(WARMUP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

    state_t           state_q, state_d;
    logic [15:0]      lfsr_q [LANES];
    logic [7:0]       thr_q;
    logic [CW-1:0]    cnt_q;
    logic             valid_q;
    logic [LANES-1:0] mask_q;
    logic [3:0]       drop_q;
    logic [15:0]      issued_q;

    logic             step;
    logic             load;
    logic             retire;
    logic [LANES-1:0] mask_d;
    logic [3:0]       drop_d;

    // Lanes get decorrelated seeds; zero would lock the LFSR.
    function automatic logic [15:0] lane_seed(
        input logic [15:0] s,
        input int          i
    );
        logic [31:0] p;
        logic [15:0] v;
        p = 32'h9E37 * 32'(i + 1);
        v = s ^ p[15:0];
        if (v == 16'h0000)
            v = 16'h0001;
        return v;
    endfunction

    function automatic logic [15:0] lfsr_next(
        input logic [15:0] s
    );
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    always_comb begin
        mask_d = '0;
        drop_d = '0;
        for (int i = 0; i < LANES; i++) begin
            mask_d[i] = (lfsr_q[i][7:0] >= thr_q);
            if (!mask_d[i])
                drop_d = drop_d + 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        step    = 1'b0;
        load    = 1'b0;
        retire  = 1'b0;
        if (bus.seed_load) begin
            state_d = bus.enable ? WARMUP : IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.enable)
                        state_d = WARMUP;
                end
                WARMUP: begin
                    if (!bus.enable) begin
                        state_d = IDLE;
                    end else begin
                        step = 1'b1;
                        if (cnt_q == LAST)
                            state_d = RUN;
                    end
                end
                RUN: begin
                    if (bus.enable) begin
                        if (!valid_q || bus.mask_ready) begin
                            load = 1'b1;
                            step = 1'b1;
                        end
                    end else if (!valid_q || bus.mask_ready) begin
                        // Pending mask (if any) is taken this cycle.
                        retire  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LANES; i++)
                lfsr_q[i] <= lane_seed(DEFAULT_SEED, i);
            thr_q    <= 8'd128;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            mask_q   <= '0;
            drop_q   <= '0;
            issued_q <= '0;
        end else if (bus.seed_load) begin
            for (int i = 0; i < LANES; i++)
                lfsr_q[i] <= lane_seed(bus.seed, i);
            thr_q    <= bus.threshold;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            issued_q <= '0;
        end else begin
            if (step) begin
                for (int i = 0; i < LANES; i++)
                    lfsr_q[i] <= lfsr_next(lfsr_q[i]);
            end
            if (state_q == WARMUP && step)
                cnt_q <= cnt_q + 1'b1;
            else if (state_q != WARMUP)
                cnt_q <= '0;
            if (load) begin
                mask_q  <= mask_d;
                drop_q  <= drop_d;
                valid_q <= 1'b1;
            end else if (retire) begin
                valid_q <= 1'b0;
            end
            if (valid_q && bus.mask_ready &&
                issued_q != 16'hFFFF)
                issued_q <= issued_q + 16'd1;
        end
    end

    assign bus.mask_valid   = valid_q;
    assign bus.mask         = mask_q;
    assign bus.drop_count   = drop_q;
    assign bus.masks_issued = issued_q;
    assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_dropout_mask_gen.sv
// Directed bench for dropout_mask_gen.
// Drives the slave side of the interface and checks outputs.
module tb_dropout_mask_gen;
    localparam int L = 8;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset_n;
    int   n_vec = 0;
    int   n_bad = 0;

    dropout_mask_gen_if #(.LANES(L)) bus ();

    dropout_mask_gen #(
        .LANES(L),
        .DEFAULT_SEED(16'hACE1),
        .WARMUP_CYCLES(W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic en;
        logic rdy;
        logic exp_valid;
        logic exp_busy;
        int   exp_iss;
        int   k;
    } vec_t;

    vec_t tbl[19];

    function automatic logic [15:0] m_seed(
        input logic [15:0] s,
        input int          i
    );
        logic [31:0] p;
        logic [15:0] v;
        p = 32'h9E37 * 32'(i + 1);
        v = s ^ p[15:0];
        if (v == 0)
            v = 16'h0001;
        return v;
    endfunction

    // Mask k of a fresh run: lanes stepped W + k times.
    function automatic logic [7:0] m_mask(
        input logic [15:0] s,
        input logic [7:0]  thr,
        input int          steps
    );
        logic [15:0] x;
        logic [7:0]  m;
        m = '0;
        for (int i = 0; i < L; i++) begin
            x = m_seed(s, i);
            for (int n = 0; n < steps; n++)
                x = {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
            m[i] = (x[7:0] >= thr);
        end
        return m;
    endfunction

    function automatic logic [3:0] zeros(input logic [7:0] m);
        logic [3:0] z;
        z = 0;
        for (int i = 0; i < L; i++)
            if (!m[i])
                z = z + 1;
        return z;
    endfunction

    task automatic check(
        input string       name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_mask(
        input string      name,
        input logic [7:0] exp
    );
        check({name, ".mask"}, 32'(bus.mask), 32'(exp));
        check({name, ".drop"}, 32'(bus.drop_count),
              32'(zeros(exp)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] m;
        int         w;

        // Post-warmup stream: accept 3, stall 10, accept 2,
        // drop enable with pending mask, then one-cycle ready.
        for (int r = 0; r < 19; r++)
            tbl[r] = '{1'b1, 1'b1, 1'b1, 1'b1, 0, 0};
        for (int r = 0; r < 3; r++) begin
            tbl[r].exp_iss = r + 1;
            tbl[r].k       = r + 1;
        end
        for (int r = 3; r < 13; r++) begin
            tbl[r].rdy     = 1'b0;
            tbl[r].exp_iss = 3;
            tbl[r].k       = 3;
        end
        tbl[13].exp_iss = 4; tbl[13].k = 4;
        tbl[14].exp_iss = 5; tbl[14].k = 5;
        tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 5, 5};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 5, 5};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 6, -1};
        tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 6, -1};

        reset_n        = 1'b0;
        bus.enable     = 1'b1;
        bus.mask_ready = 1'b1;
        bus.seed_load  = 1'b0;
        bus.seed       = 16'h0000;
        bus.threshold  = 8'd0;
        #2;
        check("rst.valid", 32'(bus.mask_valid), 0);
        check("rst.busy", 32'(bus.busy), 0);
        check("rst.mask", 32'(bus.mask), 0);
        check("rst.drop", 32'(bus.drop_count), 0);
        check("rst.issued", 32'(bus.masks_issued), 0);
        tick();
        tick();
        reset_n = 1'b1;

        // First mask lands on edge 18 after release.
        tick();
        check("wu.busy", 32'(bus.busy), 1);
        repeat (16) tick();
        check("wu.valid17", 32'(bus.mask_valid), 0);
        tick();
        check("wu.valid18", 32'(bus.mask_valid), 1);
        check("wu.issued", 32'(bus.masks_issued), 0);
        check_mask("wu.m0", m_mask(16'hACE1, 8'd128, W));

        for (int r = 0; r < 19; r++) begin
            bus.enable     = tbl[r].en;
            bus.mask_ready = tbl[r].rdy;
            tick();
            check($sformatf("tbl%0d.valid", r),
                  32'(bus.mask_valid), 32'(tbl[r].exp_valid));
            check($sformatf("tbl%0d.busy", r),
                  32'(bus.busy), 32'(tbl[r].exp_busy));
            check($sformatf("tbl%0d.issued", r),
                  32'(bus.masks_issued), 32'(tbl[r].exp_iss));
            if (tbl[r].k >= 0)
                check_mask($sformatf("tbl%0d", r),
                    m_mask(16'hACE1, 8'd128, W + tbl[r].k));
        end

        // Get a pending mask, then reseed over it.
        bus.enable     = 1'b1;
        bus.mask_ready = 1'b0;
        w = 0;
        while (!bus.mask_valid && w < 40) begin
            tick();
            w++;
        end
        check("pend.valid", 32'(bus.mask_valid), 1);
        bus.seed_load = 1'b1;
        bus.seed      = 16'h1234;
        bus.threshold = 8'd0;
        tick();
        bus.seed_load  = 1'b0;
        bus.mask_ready = 1'b1;
        check("sl.valid", 32'(bus.mask_valid), 0);
        check("sl.issued", 32'(bus.masks_issued), 0);
        check("sl.busy", 32'(bus.busy), 1);
        repeat (16) tick();
        check("sl.valid16", 32'(bus.mask_valid), 0);
        tick();
        check("sl.valid17", 32'(bus.mask_valid), 1);
        check_mask("sl.m0", 8'hFF);
        for (int k = 1; k < 4; k++) begin
            tick();
            check_mask($sformatf("thr0.m%0d", k),
                       m_mask(16'h1234, 8'd0, W + k));
            check($sformatf("thr0.iss%0d", k),
                  32'(bus.masks_issued), 32'(k));
        end

        bus.seed_load = 1'b1;
        bus.seed      = 16'hBEEF;
        bus.threshold = 8'd255;
        tick();
        bus.seed_load = 1'b0;
        repeat (17) tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("thr255.v%0d", k),
                  32'(bus.mask_valid), 1);
            check_mask($sformatf("thr255.m%0d", k),
                       m_mask(16'hBEEF, 8'd255, W + k));
            tick();
        end

        // Asynchronous reset mid-run.
        #2;
        reset_n = 1'b0;
        #1;
        check("arst.valid", 32'(bus.mask_valid), 0);
        check("arst.busy", 32'(bus.busy), 0);
        check("arst.mask", 32'(bus.mask), 0);
        check("arst.drop", 32'(bus.drop_count), 0);
        check("arst.issued", 32'(bus.masks_issued), 0);
        tick();
        reset_n = 1'b1;

        // Abort warmup after 4 steps; LFSRs keep that state.
        bus.enable = 1'b1;
        repeat (5) tick();
        bus.enable = 1'b0;
        tick();
        check("abort.busy", 32'(bus.busy), 0);
        bus.enable = 1'b1;
        tick();
        repeat (16) tick();
        check("abort.valid16", 32'(bus.mask_valid), 0);
        tick();
        check("abort.valid17", 32'(bus.mask_valid), 1);
        m = m_mask(16'hACE1, 8'd128, W + 4);
        check_mask("abort.m0", m);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/dropout_mask_gen.md
DROPOUT_MASK_GEN -- requirements
Module: dropout_mask_gen

Interface
REQ-001 SHALL have parameter LANES, default 8: number of neuron lanes, one mask bit per lane.
REQ-002 SHALL have parameter DEFAULT_SEED, default 16'hACE1: seed applied at reset.
REQ-003 SHALL have parameter WARMUP_CYCLES, default 16: LFSR steps taken before the first mask after seeding or enabling.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising-edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port enable, input, 1 bit: requests mask generation.
REQ-007 SHALL have port seed_load, input, 1 bit: one-cycle pulse that loads seed and threshold.
REQ-008 SHALL have port seed, input, 16 bits: base seed.
REQ-009 SHALL have port threshold, input, 8 bits: drop threshold, where dropout probability is threshold/256.
REQ-010 SHALL have port mask_valid, output, 1 bit: mask available.
REQ-011 SHALL have port mask_ready, input, 1 bit: downstream dropout stage accepts the mask.
REQ-012 SHALL have port mask, output, LANES bits: 1 = keep lane, 0 = drop lane.
REQ-013 SHALL have port drop_count, output, 4 bits: number of zero bits in mask.
REQ-014 SHALL have port masks_issued, output, 16 bits: count of accepted masks.
REQ-015 SHALL have port busy, output, 1 bit: high when the state is not IDLE.

Function
REQ-016 SHALL hold one 16-bit Fibonacci LFSR per lane, shifting left with new bit = s[15]^s[13]^s[12]^s[10].
REQ-017 SHALL compute lane seed i = (seed ^ (16'h9E37*(i+1)))[15:0], substituting 16'h0001 when the result is zero; no LFSR ever holds zero.
REQ-018 SHALL set mask bit i = 1 iff lfsr_i[7:0] >= thr_reg (unsigned), with thr_reg the registered threshold.
REQ-019 SHALL use FSM states IDLE, WARMUP and RUN.
REQ-020 SHALL go IDLE->WARMUP when enable=1.
REQ-021 SHALL step all LFSRs once per cycle in WARMUP and go to RUN after exactly WARMUP_CYCLES steps.
REQ-022 SHALL, in RUN while enable=1, load the mask/drop_count output registers from the current LFSR state and step every LFSR once whenever mask_valid=0 or mask_ready=1, then set mask_valid=1.
REQ-023 SHALL give first mask_valid=1 exactly WARMUP_CYCLES+2 cycles after the cycle in which enable is sampled high in IDLE.
REQ-024 SHALL hold mask, drop_count and mask_valid stable while mask_valid=1 and mask_ready=0; LFSRs SHALL NOT step in that condition.
REQ-025 SHALL sustain one mask per cycle while mask_ready is held at 1.
REQ-026 SHALL increment masks_issued on each cycle with mask_valid && mask_ready, saturating at 16'hFFFF.
REQ-027 SHALL, when enable=0 in RUN, produce no new mask; a pending valid mask SHALL stay valid until accepted, then mask_valid=0 and state->IDLE; with no pending mask, state->IDLE next cycle.
REQ-028 SHALL, when enable=0 in WARMUP, return to IDLE and keep the LFSR state.
REQ-029 SHALL give seed_load priority over all other events in any state: reload all lane seeds, set thr_reg=threshold, clear mask_valid, clear masks_issued, go to WARMUP if enable=1 else IDLE; the pending mask SHALL be discarded.
REQ-030 SHALL load thr_reg from threshold only on seed_load.
REQ-031 SHALL produce identical mask sequences for identical seed, threshold and handshake history.

Reset
REQ-032 SHALL, on reset_n=0 (asynchronous), set state=IDLE, LFSRs=lane seeds of DEFAULT_SEED, thr_reg=8'd128, mask_valid=0, mask=0, drop_count=0, masks_issued=0, busy=0.
REQ-033 SHALL resume on the first clk edge after reset_n deasserts.

Verification
REQ-034 SHALL cover: reset with enable=1, mask_ready=1 -> mask_valid rises at cycle 18, then one mask per cycle, masks_issued counts 1,2,3...
REQ-035 SHALL cover: seed_load, threshold=0 -> every mask=8'hFF with drop_count=0; threshold=255 -> mask bit set only where lfsr byte==8'hFF, matching a reference model.
REQ-036 SHALL cover: mask_ready=0 for 10 cycles mid-run -> mask, drop_count and masks_issued unchanged; on release the next mask equals the model's next value.
REQ-037 SHALL cover: seed_load mid-run with a pending mask -> mask_valid=0 next cycle, masks_issued=0, first new mask WARMUP_CYCLES+2 cycles later, equal to a fresh-seed run.
REQ-038 SHALL cover: enable dropped with a pending mask and mask_ready=0 -> mask held; after one-cycle ready, mask_valid=0 and busy=0.
REQ-039 SHALL cover: reset_n asserted mid-run -> all outputs zero immediately, without a clock edge.
